// File: rtl/mem_map_pkg.sv
// Shared types and defaults for the Avalon-MM command master.
package mem_map_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } mm_state_t;

    localparam int unsigned MM_ADDR_W  = 32;
    localparam int unsigned MM_DATA_W  = 32;
    localparam int unsigned MM_TIMEOUT = 256;

    // A disabled timeout (0) still needs a 1-bit counter to stay legal.
    function automatic int unsigned tmo_cnt_w(input int unsigned tmo);
        return (tmo == 0) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/mm_tmo_cnt.sv
// Clearable, enabled timeout counter; tc flags the last permitted cycle.
module mm_tmo_cnt
    import mem_map_pkg::*;
#(
    parameter int unsigned TIMEOUT = MM_TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = tmo_cnt_w(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign tc = 1'b0;
        end else begin : g_on
            assign tc = en && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/reg_we.sv
// Enable register with asynchronous active-low clear.
module reg_we #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_map_mst.sv
// Avalon-MM master: one outstanding read or write per command, with
// waitrequest stalls, optional readdatavalid returns and a bus timeout.
module mem_map_mst
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_W  = MM_ADDR_W,
    parameter int unsigned DATA_W  = MM_DATA_W,
    parameter int unsigned USE_RDV = 1,
    parameter int unsigned TIMEOUT = MM_TIMEOUT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                write,
    output logic                read,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                waitrequest,
    input  logic                readdatavalid
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned LAT_W = 1 + ADDR_W + DATA_W + BE_W;

    mm_state_t state, state_nx;
    logic      accept;
    logic      lat_we;
    logic      tmo_tc;
    logic      we_nx;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // The latch outputs are the Avalon address/data/byteenable themselves,
    // so they stay frozen for the whole transfer.
    reg_we #(.W(LAT_W)) u_lat (
        .clk (clk),
        .rstn(rstn),
        .en  (accept),
        .d   ({cmd_we, cmd_addr, cmd_wdata, cmd_be}),
        .q   ({lat_we, address, writedata, byteenable})
    );

    mm_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk (clk),
        .rstn(rstn),
        .clr (accept),
        .en  ((state == BUS) || (state == WAIT_RD)),
        .tc  (tmo_tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = BUS;
            BUS: begin
                if (!waitrequest)
                    state_nx = (lat_we || USE_RDV == 0) ? RESP : WAIT_RD;
                else if (tmo_tc)
                    state_nx = RESP;
            end
            WAIT_RD: if (readdatavalid || tmo_tc) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Direction for the strobe in the next cycle: fresh command or latched one.
    assign we_nx = accept ? cmd_we : lat_we;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            read      <= (state_nx == BUS) && !we_nx;
            write     <= (state_nx == BUS) && we_nx;
            rsp_valid <= (state_nx == RESP);
            rsp_err   <= 1'b0;
            if (state_nx == RESP) begin
                rsp_rdata <= '0;
                // An accept or readdatavalid in the terminal cycle beats the timeout.
                if (state == BUS && !waitrequest) begin
                    if (!lat_we && USE_RDV == 0)
                        rsp_rdata <= readdata;
                end else if (state == WAIT_RD && readdatavalid) begin
                    rsp_rdata <= readdata;
                end else begin
                    rsp_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_map_mst.sv
// Bench for mem_map_mst: one instance per read-return mode, both with a short timeout.
module tb_mem_map_mst;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid     [2];
    logic        cmd_ready     [2];
    logic        cmd_we        [2];
    logic [31:0] cmd_addr      [2];
    logic [31:0] cmd_wdata     [2];
    logic [3:0]  cmd_be        [2];
    logic        rsp_valid     [2];
    logic [31:0] rsp_rdata     [2];
    logic        rsp_err       [2];
    logic [31:0] address       [2];
    logic [31:0] writedata     [2];
    logic [3:0]  byteenable    [2];
    logic        write_s       [2];
    logic        read_s        [2];
    logic [31:0] readdata      [2];
    logic        waitrequest   [2];
    logic        readdatavalid [2];

    int vectors = 0;
    int miscompares = 0;
    int txn_id = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            mem_map_mst #(
                .ADDR_W (32),
                .DATA_W (32),
                .USE_RDV(g),
                .TIMEOUT(TMO)
            ) u_dut (
                .clk          (clk),
                .rstn         (rstn),
                .cmd_valid    (cmd_valid[g]),
                .cmd_ready    (cmd_ready[g]),
                .cmd_we       (cmd_we[g]),
                .cmd_addr     (cmd_addr[g]),
                .cmd_wdata    (cmd_wdata[g]),
                .cmd_be       (cmd_be[g]),
                .rsp_valid    (rsp_valid[g]),
                .rsp_rdata    (rsp_rdata[g]),
                .rsp_err      (rsp_err[g]),
                .address      (address[g]),
                .writedata    (writedata[g]),
                .byteenable   (byteenable[g]),
                .write        (write_s[g]),
                .read         (read_s[g]),
                .readdata     (readdata[g]),
                .waitrequest  (waitrequest[g]),
                .readdatavalid(readdatavalid[g])
            );
        end
    endgenerate

    typedef struct {
        int unsigned d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int unsigned stalls;
        int unsigned rdvd;
        logic [31:0] rdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int unsigned exp_rsp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (txn %0d cycle %0d): got %0h, expected %0h", name, txn_id, cyc, act, exp);
        end
    endtask

    // Reference: the transfer finishes in the cycle its awaited event arrives
    // (cycles counted from the accept edge), unless that is past TMO.
    function automatic vec_t model(input vec_t v);
        int unsigned ev;
        ev = v.stalls + 1;
        if (!v.we && v.d == 1)
            ev += v.rdvd;
        v.exp_err   = (ev > TMO);
        v.exp_rsp   = v.exp_err ? TMO + 1 : ev + 1;
        v.exp_rdata = (v.we || v.exp_err) ? 32'h0 : v.rdata;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int unsigned d, bus_cyc, ev, strobe_end;
        bit          rdv_mode;
        logic        act;
        d          = v.d;
        bus_cyc    = v.stalls + 1;
        rdv_mode   = (d == 1) && !v.we;
        ev         = rdv_mode ? bus_cyc + v.rdvd : bus_cyc;
        strobe_end = (bus_cyc < TMO) ? bus_cyc : TMO;
        txn_id++;
        cyc = 0;
        @(negedge clk);
        chk("idle_ready", cmd_ready[d], 1);
        chk("idle_rsp", rsp_valid[d], 0);
        cmd_valid[d]     = 1'b1;
        cmd_we[d]        = v.we;
        cmd_addr[d]      = v.addr;
        cmd_wdata[d]     = v.wdata;
        cmd_be[d]        = v.be;
        waitrequest[d]   = 1'($urandom);
        readdatavalid[d] = 1'($urandom);
        readdata[d]      = $urandom;
        for (int unsigned c = 1; c <= v.exp_rsp + 1; c++) begin
            @(negedge clk);
            cyc = c;
            act = (c <= strobe_end);
            chk("read", read_s[d], act && !v.we);
            chk("write", write_s[d], act && v.we);
            if (act) begin
                chk("address", address[d], v.addr);
                chk("writedata", writedata[d], v.wdata);
                chk("byteenable", byteenable[d], v.be);
            end
            chk("rsp_valid", rsp_valid[d], c == v.exp_rsp);
            if (c == v.exp_rsp) begin
                chk("rsp_err", rsp_err[d], v.exp_err);
                chk("rsp_rdata", rsp_rdata[d], v.exp_rdata);
            end
            chk("cmd_ready", cmd_ready[d], c == v.exp_rsp + 1);
            // Busy-time commands carry junk payload that must never be latched.
            cmd_valid[d]   = (c <= v.exp_rsp);
            cmd_we[d]      = 1'($urandom);
            cmd_addr[d]    = $urandom;
            cmd_wdata[d]   = $urandom;
            cmd_be[d]      = 4'($urandom);
            waitrequest[d] = (c < bus_cyc) ? 1'b1 : (c == bus_cyc) ? 1'b0 : 1'($urandom);
            if (rdv_mode)
                readdatavalid[d] = (c == ev) || (1'($urandom) && (c <= bus_cyc || c > ev));
            else
                readdatavalid[d] = 1'($urandom);
            readdata[d] = (c == ev && !v.we) ? v.rdata : $urandom;
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("gap_rsp", rsp_valid[k], 0);
                chk("gap_ready", cmd_ready[k], 1);
                readdatavalid[k] = 1'($urandom);
                readdata[k]      = $urandom;
            end
        end
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k]     = 1'b0;
            cmd_we[k]        = 1'b0;
            cmd_addr[k]      = '0;
            cmd_wdata[k]     = '0;
            cmd_be[k]        = '0;
            readdata[k]      = '0;
            waitrequest[k]   = 1'b0;
            readdatavalid[k] = 1'b0;
        end
        //          d  we addr           wdata          be    st  rdvd rdata          err rdata          rsp
        tbl[0]  = '{0, 1, 32'h0000_0000, 32'h0000_0001, 4'hF, 0,  1,   32'h0,         0,  32'h0,         2};
        tbl[1]  = '{0, 0, 32'h0000_0040, 32'h0000_0055, 4'hF, 3,  1,   32'hDEADBEEF,  0,  32'hDEADBEEF,  5};
        tbl[2]  = '{1, 0, 32'h0000_1000, 32'h0000_0077, 4'hF, 0,  4,   32'h12345678,  0,  32'h12345678,  6};
        tbl[3]  = '{0, 0, 32'h0000_0080, 32'h0000_0000, 4'hF, 20, 1,   32'h11111111,  1,  32'h0,         9};
        tbl[4]  = '{0, 0, 32'h0000_0084, 32'h0000_0000, 4'hF, 7,  1,   32'hA5A5A5A5,  0,  32'hA5A5A5A5,  9};
        tbl[5]  = '{1, 0, 32'h0000_2000, 32'h0000_0000, 4'hC, 2,  5,   32'hCAFEF00D,  0,  32'hCAFEF00D,  9};
        tbl[6]  = '{1, 0, 32'h0000_2004, 32'h0000_0000, 4'h3, 2,  6,   32'h0BADC0DE,  1,  32'h0,         9};
        tbl[7]  = '{1, 1, 32'h0000_3000, 32'h1234_0000, 4'hF, 7,  1,   32'h22222222,  0,  32'h0,         9};
        tbl[8]  = '{1, 1, 32'h0000_3004, 32'h5678_0000, 4'hF, 8,  1,   32'h33333333,  1,  32'h0,         9};
        tbl[9]  = '{0, 1, 32'hFFFF_FFFC, 32'hFFFF_0000, 4'h3, 1,  1,   32'h0,         0,  32'h0,         3};
        tbl[10] = '{1, 1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 0,  1,   32'h0,         0,  32'h0,         2};
        tbl[11] = '{1, 0, 32'h0000_0014, 32'h0000_0000, 4'hF, 1,  1,   32'h00000001,  0,  32'h00000001,  4};

        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", cmd_ready[k], 1);
            chk("rst_rsp_valid", rsp_valid[k], 0);
            chk("rst_rsp_err", rsp_err[k], 0);
            chk("rst_rw", {read_s[k], write_s[k]}, 0);
            chk("rst_address", address[k], 0);
            chk("rst_rdata", rsp_rdata[k], 0);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i]);
            idle_gap(2);
        end

        // Asynchronous reset in the middle of a stalled write.
        txn_id++;
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_we[0]    = 1'b1;
        cmd_addr[0]  = 32'h0000_0200;
        cmd_wdata[0] = 32'h0BEE_F000;
        cmd_be[0]    = 4'hF;
        waitrequest[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        chk("pre_rst_write", write_s[0], 1);
        chk("pre_rst_addr", address[0], 32'h200);
        @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_write", write_s[0], 0);
        chk("mid_rst_read", read_s[0], 0);
        chk("mid_rst_rsp", rsp_valid[0], 0);
        chk("mid_rst_ready", cmd_ready[0], 1);
        chk("mid_rst_addr", address[0], 0);
        chk("mid_rst_wdata", writedata[0], 0);
        chk("mid_rst_be", byteenable[0], 0);
        @(negedge clk);
        rstn = 1'b1;
        waitrequest[0] = 1'b0;
        idle_gap(10);
        run_txn(tbl[0]);
        run_txn(tbl[2]);

        for (int n = 0; n < 80; n++) begin
            rv.d      = $urandom_range(0, 1);
            rv.we     = 1'($urandom);
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.be     = 4'($urandom);
            rv.stalls = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 3);
            rv.rdvd   = $urandom_range(1, 8);
            rv.rdata  = $urandom;
            rv = model(rv);
            run_txn(rv);
            if ($urandom_range(0, 2) == 0)
                idle_gap($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_map_mst.md
# mem_map_mst

Avalon memory-mapped master (initiator) that turns single read/write commands from a simple valid/ready command port into Avalon-MM transfers, one outstanding at a time. It drives the slave side of memory-mapped peripherals such as the reset and control registers, and lets a sequencer or test FSM access them without a soft CPU. It handles `waitrequest` stalls, optional pipelined read latency, and a bus timeout that returns an error response.

## Interface
- `ADDR_W`, 32, Avalon address width
- `DATA_W`, 32, data width; multiple of 8
- `USE_RDV`, 1, 1: read data returns on `readdatavalid`; 0: read data sampled in the accept cycle
- `TIMEOUT`, 256, maximum cycles spent in BUS plus WAIT_RD before an error response; 0 disables the timeout
- `clk`  in  1  clock; single clock domain
- `rstn`  in  1  reset; asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block idle; a command is accepted when `cmd_valid && cmd_ready`
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `cmd_be`  in  DATA_W/8  byte enables
- `rsp_valid`  out  1  one-cycle response strobe; no backpressure
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and on error
- `rsp_err`  out  1  timeout occurred
- `address`  out  ADDR_W  Avalon address
- `writedata`  out  DATA_W  Avalon write data
- `byteenable`  out  DATA_W/8  Avalon byte enables
- `write`  out  1  Avalon write
- `read`  out  1  Avalon read
- `readdata`  in  DATA_W  Avalon read data
- `waitrequest`  in  1  slave stall; tie to 0 for slaves that have no stall
- `readdatavalid`  in  1  pipelined read return; ignored when USE_RDV=0

## Operation
- State machine states: IDLE, BUS, WAIT_RD, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch addr/wdata/be/we and go to BUS.
- BUS:
  - Drive `read` or `write` (exactly one) plus the latched fields.
  - Hold all of them stable while `waitrequest`=1.
  - Accept happens on a clock edge where `waitrequest`=0.
  - Write accept → RESP.
  - Read accept with USE_RDV=0 → capture `readdata` in that cycle, then RESP.
  - Read accept with USE_RDV=1 → WAIT_RD.
- WAIT_RD:
  - `read`=0.
  - On `readdatavalid`=1, capture `readdata`, then RESP.
  - `readdatavalid` seen in any other state is ignored.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- Timeout counter:
  - Cleared on command accept.
  - Increments every cycle spent in BUS or WAIT_RD.
  - When the count equals TIMEOUT-1 and the awaited event has not occurred in that cycle: drop `read`/`write`, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - Counter width is $clog2(TIMEOUT+1).
- Simultaneous events:
  - Accept or `readdatavalid` in the timeout cycle wins; the response is then normal with `rsp_err`=0.
  - `cmd_valid` while not IDLE is ignored and not queued.
- Reset, asynchronous and possible mid-transfer:
  - State returns to IDLE.
  - `read`, `write`, `rsp_valid`, `rsp_err` are 0.
  - `address`, `writedata`, `byteenable`, `rsp_rdata` are 0.
  - `cmd_ready` is 1 (combinational from IDLE).
  - An in-flight transfer is abandoned with no response.
- `writedata` is driven for reads as well (latched value); slaves ignore it.

## Timing
- Command accepted at edge 0.
- `read`/`write` asserted in cycle 1.
- Write, or USE_RDV=0 read, with no stall:
  - Accepted at edge 1.
  - `rsp_valid` in cycle 2.
  - `cmd_ready` in cycle 3.
- Each `waitrequest` stall cycle adds 1 cycle.
- USE_RDV=1 read: `rsp_valid` comes one cycle after the `readdatavalid` cycle.
- Peak throughput: one transfer per 3 cycles.
- All outputs are registered except `cmd_ready`.

## Structure
- Shared package `mem_map_pkg` holds:
  - the state enum `mm_state_t` (IDLE, BUS, WAIT_RD, RESP);
  - default widths and the default timeout constants.
- The command latch registers use the existing `reg_we` enable register, with enable = accept.
- One new sub-module is natural: `mm_tmo_cnt` (clearable, enabled, terminal-count timeout counter).

## Test plan
- Write, no stall:
  - Stimulus: cmd addr=0x0, wdata=0x1, be=0xF, `waitrequest`=0.
  - Response: `write`=1 for exactly 1 cycle with `address`=0, `writedata`=1; `rsp_valid` 2 cycles after accept with `rsp_err`=0.
- Read with 3 stall cycles, USE_RDV=0:
  - Stimulus: `readdata`=0xDEADBEEF in the accept cycle.
  - Response: `read` held 4 cycles with address stable; `rsp_rdata`=0xDEADBEEF.
- Pipelined read, USE_RDV=1:
  - Stimulus: `readdatavalid` 5 cycles after accept with data 0x12345678.
  - Response: `read` deasserted in WAIT_RD; `rsp_rdata`=0x12345678; a stray `readdatavalid` while IDLE produces no response.
- Timeout:
  - TIMEOUT=8 with `waitrequest` stuck at 1: `read` is dropped after 8 cycles, then `rsp_err`=1 and `rsp_rdata`=0.
  - Repeat with `waitrequest`=0 exactly in the 8th cycle: `rsp_err`=0.
- Back-to-back commands:
  - Stimulus: `cmd_valid` held high with changing payload.
  - Response: payload is captured only when `cmd_ready`=1, and latched fields do not change during BUS.
- Reset mid-transfer:
  - Stimulus: `rstn` pulsed low during a BUS stall.
  - Response: `write`/`read`/`rsp_valid` go to 0 asynchronously and `cmd_ready`=1; no response is issued; the next command completes normally.
